// File: rtl/instr_encoder_loader_if.sv
// Request/response bundle for instr_encoder_loader.
// Carries the instruction-field request handshake, the instruction-memory
// write port and the status outputs. master = requester/bench, slave = loader.
interface instr_encoder_loader_if #(
   parameter int IMEM_DEPTH = 64
);
   localparam int CW = $clog2(IMEM_DEPTH + 1);

   // request side
   logic          i_clear;
   logic          i_valid;
   logic          o_ready;
   logic [6:0]    i_opcode;
   logic [4:0]    i_rd;
   logic [4:0]    i_rs1;
   logic [4:0]    i_rs2;
   logic [2:0]    i_funct3;
   logic          i_funct7bit5;
   logic [11:0]   i_imm;

   // instruction-memory write port and status
   logic          o_imemWriteEn;
   logic [31:0]   o_imemAddr;
   logic [31:0]   o_imemWriteData;
   logic          o_illegal;
   logic          o_full;
   logic [CW-1:0] o_count;

   modport master (
      output i_clear, i_valid, i_opcode, i_rd, i_rs1, i_rs2,
             i_funct3, i_funct7bit5, i_imm,
      input  o_ready, o_imemWriteEn, o_imemAddr, o_imemWriteData,
             o_illegal, o_full, o_count
   );

   modport slave (
      input  i_clear, i_valid, i_opcode, i_rd, i_rs1, i_rs2,
             i_funct3, i_funct7bit5, i_imm,
      output o_ready, o_imemWriteEn, o_imemAddr, o_imemWriteData,
             o_illegal, o_full, o_count
   );
endinterface

// File: rtl/instr_encoder_loader.sv
// Purpose : packs RV32I I(load)/S/R instruction fields into machine words and
//           writes them to consecutive word addresses of instruction memory.
// Latency : accept at edge N -> write strobe in cycle N+1 -> count updated after N+1.
// Backpr. : o_ready low while writing or full; a pending request waits upstream.
// Ports   : i_clk, i_arst_n (async active-low); bus (slave) carries the
//           request fields + valid/ready, i_clear, the imem write port
//           (strobe/byte address/data) and illegal/full/count status.
module instr_encoder_loader #(
   parameter int IMEM_DEPTH = 64
) (
   input  logic                  i_clk,
   input  logic                  i_arst_n,
   instr_encoder_loader_if.slave bus
);

   localparam int PW = $clog2(IMEM_DEPTH);
   localparam int CW = $clog2(IMEM_DEPTH + 1);

   localparam logic [6:0]    OP_I    = 7'b0000011;
   localparam logic [6:0]    OP_S    = 7'b0100011;
   localparam logic [6:0]    OP_R    = 7'b0110011;
   localparam logic [CW-1:0] DEPTH_C = CW'(IMEM_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WRITE = 2'd1,
      S_FULL  = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic [PW-1:0]   ptr_q,   ptr_d;
   logic [CW-1:0]   cnt_q,   cnt_d;
   logic [31:0]     word_q,  word_d;
   logic            ill_q,   ill_d;

   logic [31:0]     enc;
   logic            legal;
   logic [CW-1:0]   cnt_inc;

   assign cnt_inc = cnt_q + CW'(1);

   // Field packing; fields a format does not use simply never reach the word.
   always_comb begin
      enc   = 32'h0;
      legal = 1'b0;
      case (bus.i_opcode)
         OP_I: begin
            legal = 1'b1;
            enc   = {bus.i_imm, bus.i_rs1, bus.i_funct3, bus.i_rd, bus.i_opcode};
         end
         OP_S: begin
            legal = 1'b1;
            enc   = {bus.i_imm[11:5], bus.i_rs2, bus.i_rs1, bus.i_funct3,
                     bus.i_imm[4:0], bus.i_opcode};
         end
         OP_R: begin
            legal = 1'b1;
            enc   = {1'b0, bus.i_funct7bit5, 5'b0, bus.i_rs2, bus.i_rs1,
                     bus.i_funct3, bus.i_rd, bus.i_opcode};
         end
         default: begin
            legal = 1'b0;
            enc   = 32'h0;
         end
      endcase
   end

   // State register. Reset is asynchronous so a write in flight is dropped at once.
   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         cnt_q   <= '0;
         word_q  <= 32'h0;
         ill_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         word_q  <= word_d;
         ill_q   <= ill_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      word_d  = word_q;
      ill_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.i_clear) begin
               // clear wins over a simultaneous request: nothing accepted
               ptr_d = '0;
               cnt_d = '0;
            end else if (bus.i_valid) begin
               if (legal) begin
                  // word is captured only on a legal accept, so the data
                  // output holds its last value between strobes
                  word_d  = enc;
                  state_d = S_WRITE;
               end else begin
                  ill_d = 1'b1;
               end
            end
         end
         S_WRITE: begin
            if (bus.i_clear) begin
               // the strobe of this cycle still lands at the old address
               ptr_d   = '0;
               cnt_d   = '0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc == DEPTH_C) begin
                  // pointer is left on the last slot rather than wrapping
                  state_d = S_FULL;
               end else begin
                  ptr_d   = ptr_q + PW'(1);
                  state_d = S_IDLE;
               end
            end
         end
         S_FULL: begin
            if (bus.i_clear) begin
               ptr_d   = '0;
               cnt_d   = '0;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs: all from registers except the i_clear term of o_ready.
   always_comb begin
      bus.o_ready         = (state_q == S_IDLE) && !bus.i_clear;
      bus.o_imemWriteEn   = (state_q == S_WRITE);
      bus.o_imemAddr      = 32'(ptr_q) << 2;
      bus.o_imemWriteData = word_q;
      bus.o_illegal       = ill_q;
      bus.o_full          = (state_q == S_FULL);
      bus.o_count         = cnt_q;
   end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: directed scenarios followed by random
// requests; expected strobes/illegal pulses are queued at accept time and a
// separate monitor pops and compares them whenever the DUT presents output.
module tb_instr_encoder_loader;

   localparam int DEPTH = 4;
   localparam logic [6:0] OP_I = 7'b0000011;
   localparam logic [6:0] OP_S = 7'b0100011;
   localparam logic [6:0] OP_R = 7'b0110011;

   logic clk = 1'b0;
   logic arst_n = 1'b0;
   always #5 clk = ~clk;

   instr_encoder_loader_if #(.IMEM_DEPTH(DEPTH)) bus ();

   instr_encoder_loader #(.IMEM_DEPTH(DEPTH)) dut (
      .i_clk    (clk),
      .i_arst_n (arst_n),
      .bus      (bus)
   );

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int model_cnt = 0;

   typedef struct {
      bit          ill;
      logic [31:0] addr;
      logic [31:0] data;
      int          cyc;
   } exp_t;
   exp_t q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit is_legal(input logic [6:0] op);
      return (op == OP_I) || (op == OP_S) || (op == OP_R);
   endfunction

   // Reference encoding built from field weights (bit position = power of two).
   function automatic logic [31:0] ref_enc(input logic [6:0] op, input logic [4:0] rd,
         input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
         input logic f7, input logic [11:0] imm);
      int unsigned w;
      w = op;
      if (op == OP_I)
         w += rd * 128 + f3 * 4096 + rs1 * 32768 + imm * 1048576;
      else if (op == OP_S)
         w += (imm % 32) * 128 + f3 * 4096 + rs1 * 32768 + rs2 * 1048576
              + (imm / 32) * 33554432;
      else if (op == OP_R)
         w += rd * 128 + f3 * 4096 + rs1 * 32768 + rs2 * 1048576 + f7 * 1073741824;
      return w;
   endfunction

   // Monitor: every strobe or illegal pulse must match the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (arst_n && (bus.o_imemWriteEn || bus.o_illegal)) begin
            if (q.size() == 0) begin
               check("unexpected_output", {30'b0, bus.o_imemWriteEn, bus.o_illegal}, 32'h0);
            end else begin
               e = q.pop_front();
               check("out_kind", {31'b0, bus.o_illegal}, {31'b0, e.ill});
               check("out_cycle", cyc, e.cyc);
               if (!e.ill) begin
                  check("imem_addr", bus.o_imemAddr, e.addr);
                  check("imem_data", bus.o_imemWriteData, e.data);
               end
            end
         end
      end
   end

   task automatic set_fields(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
         input logic [4:0] rs2, input logic [2:0] f3, input logic f7, input logic [11:0] imm);
      bus.i_opcode     = op;
      bus.i_rd         = rd;
      bus.i_rs1        = rs1;
      bus.i_rs2        = rs2;
      bus.i_funct3     = f3;
      bus.i_funct7bit5 = f7;
      bus.i_imm        = imm;
   endtask

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
         input logic [4:0] rs2, input logic [2:0] f3, input logic f7, input logic [11:0] imm,
         input bit keep, input bit use_want, input logic [31:0] want);
      bit acc;
      exp_t e;
      set_fields(op, rd, rs1, rs2, f3, f7, imm);
      bus.i_valid = 1'b1;
      acc = 1'b0;
      for (int w = 0; w < 20 && !acc; w++) begin
         @(negedge clk);
         if (bus.o_ready) acc = 1'b1;
         @(posedge clk);
      end
      #1;
      if (!keep) bus.i_valid = 1'b0;
      if (!acc) begin
         check("accept_timeout", 32'h0, 32'h1);
      end else begin
         e.ill  = !is_legal(op);
         e.addr = model_cnt * 4;
         e.data = use_want ? want : ref_enc(op, rd, rs1, rs2, f3, f7, imm);
         e.cyc  = cyc;
         q.push_back(e);
         if (!e.ill) model_cnt++;
      end
   endtask

   task automatic do_clear();
      bus.i_clear = 1'b1;
      @(posedge clk);
      #1;
      bus.i_clear = 1'b0;
      model_cnt = 0;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_ready"}, {31'b0, bus.o_ready}, 32'h1);
      check({tag, "_we"}, {31'b0, bus.o_imemWriteEn}, 32'h0);
      check({tag, "_addr"}, bus.o_imemAddr, 32'h0);
      check({tag, "_data"}, bus.o_imemWriteData, 32'h0);
      check({tag, "_illegal"}, {31'b0, bus.o_illegal}, 32'h0);
      check({tag, "_full"}, {31'b0, bus.o_full}, 32'h0);
      check({tag, "_count"}, 32'(bus.o_count), 32'h0);
   endtask

   task automatic wait_check_count(input string tag);
      @(posedge clk);
      #1;
      check({tag, "_count"}, 32'(bus.o_count), model_cnt);
      check({tag, "_full"}, {31'b0, bus.o_full}, {31'b0, model_cnt == DEPTH});
   endtask

   initial begin
      exp_t dummy;
      logic [6:0] op;
      int r;
      bus.i_clear = 1'b0;
      bus.i_valid = 1'b0;
      set_fields(7'h0, 5'h0, 5'h0, 5'h0, 3'h0, 1'b0, 12'h0);

      // reset values while held, then after release
      #12;
      check_reset_vals("rst_held");
      @(negedge clk);
      arst_n = 1'b1;
      @(posedge clk);
      #1;
      check_reset_vals("rst_rel");

      // lw x6,-4(x9) then sw x6,8(x9) back to back
      send(OP_I, 5'd6, 5'd9, 5'd0, 3'b010, 1'b0, 12'hFFC, 1'b0, 1'b1, 32'hFFC4A303);
      send(OP_S, 5'd0, 5'd9, 5'd6, 3'b010, 1'b0, 12'h008, 1'b0, 1'b1, 32'h0064A423);
      wait_check_count("after_sw");

      // illegal opcode: pulse, no strobe, count unchanged, still ready
      send(7'h13, 5'd1, 5'd2, 5'd3, 3'b000, 1'b0, 12'h001, 1'b0, 1'b0, 32'h0);
      check("illegal_ready", {31'b0, bus.o_ready}, 32'h1);
      wait_check_count("after_illegal");

      // add/sub with valid held high -> fills DEPTH=4
      send(OP_R, 5'd4, 5'd5, 5'd6, 3'b000, 1'b0, 12'h000, 1'b1, 1'b1, 32'h00628233);
      send(OP_R, 5'd4, 5'd5, 5'd6, 3'b000, 1'b1, 12'h000, 1'b0, 1'b1, 32'h40628233);
      wait_check_count("after_sub");

      // fifth request is held while full
      set_fields(OP_I, 5'd1, 5'd2, 5'd0, 3'b010, 1'b0, 12'h010);
      bus.i_valid = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("full_ready", {31'b0, bus.o_ready}, 32'h0);
      check("full_flag", {31'b0, bus.o_full}, 32'h1);
      check("full_count", 32'(bus.o_count), DEPTH);
      do_clear();
      check("clr_full_count", 32'(bus.o_count), 32'h0);
      check("clr_full_flag", {31'b0, bus.o_full}, 32'h0);
      send(OP_I, 5'd1, 5'd2, 5'd0, 3'b010, 1'b0, 12'h010, 1'b0, 1'b0, 32'h0);   // lands at 0x0
      send(OP_S, 5'd0, 5'd3, 5'd4, 3'b000, 1'b0, 12'h7E5, 1'b0, 1'b0, 32'h0);   // 0x4

      // clear during the write of word 2: lands at 0x8, then count 0
      send(OP_R, 5'd7, 5'd8, 5'd9, 3'b111, 1'b0, 12'h000, 1'b0, 1'b0, 32'h0);
      do_clear();
      check("clr_write_count", 32'(bus.o_count), 32'h0);
      send(OP_I, 5'd3, 5'd4, 5'd0, 3'b001, 1'b0, 12'h123, 1'b0, 1'b0, 32'h0);   // 0x0
      wait_check_count("after_clr_write");

      // clear together with valid in IDLE: no accept in that cycle
      set_fields(OP_S, 5'd0, 5'd10, 5'd11, 3'b001, 1'b0, 12'h0A5);
      bus.i_valid = 1'b1;
      bus.i_clear = 1'b1;
      @(negedge clk);
      check("clr_valid_ready", {31'b0, bus.o_ready}, 32'h0);
      @(posedge clk);
      #1;
      bus.i_clear = 1'b0;
      model_cnt = 0;
      check("clr_valid_count", 32'(bus.o_count), 32'h0);
      send(OP_S, 5'd0, 5'd10, 5'd11, 3'b001, 1'b0, 12'h0A5, 1'b0, 1'b0, 32'h0);
      wait_check_count("after_clr_valid");

      // async reset mid-write drops the write immediately
      send(OP_R, 5'd1, 5'd1, 5'd1, 3'b000, 1'b1, 12'h000, 1'b0, 1'b0, 32'h0);
      #2;
      arst_n = 1'b0;
      #1;
      check_reset_vals("rst_mid");
      dummy = q.pop_back();
      @(negedge clk);
      #1;
      arst_n = 1'b1;
      model_cnt = 0;
      @(posedge clk);
      #1;
      check_reset_vals("rst_mid_rel");

      // random traffic
      for (int i = 0; i < 60; i++) begin
         if (model_cnt == DEPTH || $urandom_range(0, 9) == 0) do_clear();
         r = $urandom_range(0, 9);
         if (r < 3)      op = OP_I;
         else if (r < 6) op = OP_S;
         else if (r < 9) op = OP_R;
         else begin
            op = 7'($urandom_range(0, 127));
            while (is_legal(op)) op = 7'($urandom_range(0, 127));
         end
         send(op, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
              5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)), 12'($urandom_range(0, 4095)),
              1'b0, 1'b0, 32'h0);
         wait_check_count("rand");
      end

      repeat (3) @(posedge clk);
      #1;
      check("queue_drained", q.size(), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

endmodule

// File: doc/instr_encoder_loader.md
# instr_encoder_loader

Sequential RV32I instruction encoder and instruction-memory loader; the encode-side counterpart of the main decoder in the single-cycle core.
- Accepts instruction fields (opcode, register indices, funct3, funct7 bit 5, immediate) over a valid/ready handshake.
- Packs them into 32-bit machine words for the I-type (load), S-type and R-type formats defined in pa_riscv.
- Writes the words to consecutive word-aligned locations of instruction memory.
- Used by testbenches and the boot path to build programs in place.

## Interface
- IMEM_DEPTH, 64: instruction memory depth in 32-bit words; at least 2.
- i_clk  input  1  clock; all state updates on its rising edge.
- i_arst_n  input  1  asynchronous active-low reset.
- i_clear  input  1  synchronous; sets write pointer and count back to 0.
- i_valid  input  1  request valid.
- o_ready  output  1  request can be accepted this cycle.
- i_opcode  input  7  pa_riscv opcode: I (0000011), S (0100011) or R (0110011).
- i_rd, i_rs1, i_rs2  input  5 each  register indices.
- i_funct3  input  3  funct3 field.
- i_funct7bit5  input  1  bit 5 of funct7; R-type only.
- i_imm  input  12  immediate; I/S only.
- o_imemWriteEn  output  1  single-cycle write strobe.
- o_imemAddr  output  32  byte address, always a multiple of 4.
- o_imemWriteData  output  32  encoded instruction.
- o_illegal  output  1  one-cycle pulse for an accepted unsupported opcode.
- o_full  output  1  IMEM_DEPTH words have been written.
- o_count  output  $clog2(IMEM_DEPTH+1)  number of words written.

## Operation
- FSM states: IDLE, WRITE, FULL. Reset state is IDLE.
- IDLE: o_ready = !i_clear. A request is accepted when i_valid && o_ready at a clock edge; all fields are then registered.
  - Supported opcode: go to WRITE.
  - Unsupported opcode: pulse o_illegal in the next cycle, stay in IDLE, no write, pointer unchanged.
- WRITE: o_ready = 0. Drive o_imemWriteEn = 1, o_imemAddr = ptr*4 and o_imemWriteData = encoded word for exactly one cycle. Then ptr and o_count increment by 1.
  - Next state is FULL if the new count equals IMEM_DEPTH, otherwise IDLE.
- FULL: o_ready = 0, o_full = 1. i_valid is ignored and the request stays pending upstream. Only i_clear (to IDLE) or reset leaves FULL.
- Encoding rules:
  - I: {imm[11:0], rs1, funct3, rd, opcode}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - R: {1'b0, funct7bit5, 5'b0, rs2, rs1, funct3, rd, opcode}.
  - Fields that a format does not use are ignored.
- Pointer width is $clog2(IMEM_DEPTH). Addresses never wrap; FULL stops further writes instead.
- i_clear in IDLE or FULL: ptr = 0 and count = 0 at the next edge, state goes to IDLE, and no request is accepted in that cycle.
- i_clear in WRITE: the write completes at the old address, then ptr and count go to 0 (clear takes priority over the increment), and the state goes to IDLE.
- While o_imemWriteEn = 0, o_imemWriteData holds its last value. Consumers must only sample it under the strobe.

## Timing
- Reset values: o_ready = 1, o_imemWriteEn = 0, o_imemAddr = 0, o_imemWriteData = 0, o_illegal = 0, o_full = 0, o_count = 0.
- Reset asserted mid-WRITE aborts the write immediately (asynchronous); no partial state survives.
- Latency: request accepted at edge N → write strobe during cycle N+1 → o_count updated after edge N+1.
- Throughput: one instruction every 2 cycles. o_ready is low in WRITE, so back-to-back requests are accepted at edges N and N+2.
- An illegal request also uses one accept edge, with o_illegal high during cycle N+1. o_ready stays high, so a new request can be accepted at edge N+1.
- o_full rises in the cycle after the last write strobe and remains high until i_clear or reset.
- All outputs are registered; there are no combinational paths from inputs to outputs except o_ready from i_clear.

## Test plan
- Reset check: assert i_arst_n = 0 asynchronously mid-cycle → every output equals its reset value immediately, and again after release.
- I-type: lw x6,-4(x9), i.e. opcode I, rd=6, rs1=9, funct3=010, imm=0xFFC → one strobe with addr 0x0, data 0xFFC4A303, o_count = 1.
- S-type: sw x6,8(x9), i.e. rs2=6, rs1=9, funct3=010, imm=0x008, sent right after the I-type → data 0x0064A423 at addr 0x4.
- R-type: add x4,x5,x6 then sub x4,x5,x6 (funct7bit5 = 1), i_valid held high → data 0x00628233 and 0x40628233 on strobes 2 cycles apart.
- Illegal then full:
  - Opcode 0x13 → o_illegal pulse, no strobe, count unchanged.
  - Then with IMEM_DEPTH = 4, fill 4 words → o_full = 1, o_ready = 0, a 5th request is held with no strobe.
- Clear: i_clear during WRITE of word 2 → the write lands at 0x8, then o_count = 0, and the next write goes to 0x0. i_clear together with i_valid in IDLE → no accept that cycle.
